// File: rtl/transfer_sequencer_pkg.sv
// Shared definitions for the multi-register transfer sequencer: state encoding,
// incrementor control codes and the pending-list bit-clear helper.
package transfer_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_LOAD    = 2'd1;
    localparam state_t ST_REQUEST = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

    localparam logic [2:0] CTRL_HOLD = 3'd0;
    localparam logic [2:0] CTRL_INC  = 3'd1;
    localparam logic [2:0] CTRL_DEC  = 3'd2;
    localparam logic [2:0] CTRL_MAX  = 3'd3;
    localparam logic [2:0] CTRL_LOAD = 3'd4;

    function automatic logic [7:0] clear_bit(input logic [7:0] list, input logic [2:0] idx);
        clear_bit = list & ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/transfer_sequencer_register_list_encoder.sv
// Finds the lowest (ascending) or highest (descending) set bit of a register list.
module transfer_sequencer_register_list_encoder (
    input  logic [7:0] register_list,
    input  logic       descending,
    output logic [2:0] index,
    output logic       empty
);

    // Priority scan; the last hit in scan order wins
    always_comb begin
        index = 3'd0;
        empty = (register_list == 8'd0);
        if (descending) begin
            for (int i = 0; i < 8; i++) begin
                index = register_list[i] ? 3'(i) : index;
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                index = register_list[i] ? 3'(i) : index;
            end
        end
    end

endmodule

// File: rtl/transfer_sequencer.sv
// LDM/STM/PUSH/POP sequencer: walks a register list and steers the downstream
// address incrementor, issuing one memory request per listed register.
module transfer_sequencer
    import transfer_sequencer_pkg::*;
#(
    parameter int PACE       = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base_address,
    input  logic [7:0]            register_list,
    input  logic                  descending,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] address_in,
    input  logic                  mem_ready,
    output logic [2:0]            incrementor_control,
    output logic [DATA_WIDTH-1:0] new_address,
    output logic [DATA_WIDTH-1:0] address,
    output logic                  mem_request,
    output logic                  mem_write,
    output logic [2:0]            register_index,
    output logic                  busy,
    output logic                  done
);

    localparam logic [DATA_WIDTH-1:0] PACE_W = DATA_WIDTH'(PACE);

    state_t                  state_r;
    state_t                  state_next_s;
    logic [7:0]              list_r;
    logic                    desc_r;
    logic                    write_r;
    logic [DATA_WIDTH-1:0]   base_r;
    logic [DATA_WIDTH-1:0]   address_r;
    logic [2:0]              index_s;
    logic                    empty_s;
    logic [7:0]              list_cleared_s;

    transfer_sequencer_register_list_encoder u_encoder (
        .register_list (list_r),
        .descending    (desc_r),
        .index         (index_s),
        .empty         (empty_s)
    );

    assign list_cleared_s = clear_bit(list_r, index_s);
    assign address        = address_r;
    assign mem_write      = write_r;
    // Decrement-before starts one step below the base
    assign new_address    = (desc_r && !empty_s) ? (base_r - PACE_W) : base_r;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Address follower, transfer parameters and pending list
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            address_r <= '0;
            list_r    <= 8'd0;
            desc_r    <= 1'b0;
            write_r   <= 1'b0;
            base_r    <= '0;
        end else begin
            address_r <= address_in;
            if (state_r == ST_IDLE && start) begin
                list_r  <= register_list;
                desc_r  <= descending;
                write_r <= write;
                base_r  <= base_address;
            end else if (state_r == ST_REQUEST && mem_ready) begin
                list_r  <= list_cleared_s;
            end else begin
                list_r  <= list_r;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:    state_next_s = start ? ST_LOAD : ST_IDLE;
            ST_LOAD:    state_next_s = empty_s ? ST_DONE : ST_REQUEST;
            ST_REQUEST: state_next_s = (mem_ready && list_cleared_s == 8'd0) ? ST_DONE : ST_REQUEST;
            ST_DONE:    state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // Outputs; control in REQUEST follows mem_ready combinationally
    always_comb begin
        incrementor_control = CTRL_HOLD;
        mem_request         = 1'b0;
        register_index      = 3'd0;
        busy                = 1'b1;
        done                = 1'b0;
        case (state_r)
            ST_IDLE: busy = 1'b0;
            ST_LOAD: incrementor_control = CTRL_LOAD;
            ST_REQUEST: begin
                mem_request    = 1'b1;
                register_index = index_s;
                if (!mem_ready) begin
                    incrementor_control = CTRL_HOLD;
                end else if (list_cleared_s != 8'd0) begin
                    incrementor_control = desc_r ? CTRL_DEC : CTRL_INC;
                end else begin
                    // Descending writeback equals the last access address
                    incrementor_control = desc_r ? CTRL_HOLD : CTRL_INC;
                end
            end
            ST_DONE: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_transfer_sequencer.sv
// Scoreboard bench for transfer_sequencer with a behavioural incrementor and
// a list-walking reference model.
module tb_transfer_sequencer;

    localparam int PACE = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_address = 32'd0;
    logic [7:0]  register_list = 8'd0;
    logic        descending = 1'b0;
    logic        write = 1'b0;
    logic [31:0] address_in;
    logic        mem_ready = 1'b1;
    logic [2:0]  incrementor_control;
    logic [31:0] new_address;
    logic [31:0] address;
    logic        mem_request;
    logic        mem_write;
    logic [2:0]  register_index;
    logic        busy;
    logic        done;

    transfer_sequencer #(.PACE(PACE), .DATA_WIDTH(32)) dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .base_address        (base_address),
        .register_list       (register_list),
        .descending          (descending),
        .write               (write),
        .address_in          (address_in),
        .mem_ready           (mem_ready),
        .incrementor_control (incrementor_control),
        .new_address         (new_address),
        .address             (address),
        .mem_request         (mem_request),
        .mem_write           (mem_write),
        .register_index      (register_index),
        .busy                (busy),
        .done                (done)
    );

    always #5 clock = ~clock;

    // Downstream incrementor stage
    always_comb begin
        case (incrementor_control)
            3'd0:    address_in = address;
            3'd1:    address_in = address + 32'(PACE);
            3'd2:    address_in = address - 32'(PACE);
            3'd4:    address_in = new_address;
            default: address_in = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  idx;
        logic        wr;
    } req_t;

    req_t        req_q[$];
    logic [31:0] load_q[$];
    logic [31:0] done_q[$];

    int vectors = 0;
    int miscompares = 0;
    int stall_cycles = 0;
    int ready_mode = 0;
    int directed_stalls = 0;
    logic cur_desc = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void flag(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event seen with nothing expected", name);
    endfunction

    // Reference model: the address sequence follows directly from the list bits
    task automatic expect_transfer(input logic [31:0] base, input logic [7:0] list,
                                   input logic desc, input logic wr, output int n);
        req_t r;
        n = 0;
        if (!desc) begin
            for (int i = 0; i < 8; i++) begin
                if (list[i]) begin
                    r.addr = base + 32'(n * PACE);
                    r.idx  = 3'(i);
                    r.wr   = wr;
                    req_q.push_back(r);
                    n++;
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (list[i]) begin
                    n++;
                    r.addr = base - 32'(n * PACE);
                    r.idx  = 3'(i);
                    r.wr   = wr;
                    req_q.push_back(r);
                end
            end
        end
        load_q.push_back((desc && list != 8'd0) ? base - 32'(PACE) : base);
        done_q.push_back(desc ? base - 32'(n * PACE) : base + 32'(n * PACE));
    endtask

    // mem_ready generator
    always @(posedge clock) begin
        #1;
        case (ready_mode)
            1: mem_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (mem_request && register_index == 3'd1 && directed_stalls < 3) begin
                    mem_ready = 1'b0;
                    directed_stalls++;
                end else begin
                    mem_ready = 1'b1;
                end
            end
            default: mem_ready = 1'b1;
        endcase
    end

    // Monitor: compares presented outputs against the scoreboard
    always @(negedge clock) begin
        req_t h;
        logic [31:0] e;
        if (reset) begin
            if (busy && !mem_request && !done) begin
                if (load_q.size() == 0) flag("unexpected_load");
                else begin
                    e = load_q.pop_front();
                    check("load_ctrl", 64'(incrementor_control), 64'd4);
                    check("load_new_address", 64'(new_address), 64'(e));
                end
            end
            if (mem_request) begin
                if (req_q.size() == 0) flag("unexpected_request");
                else begin
                    h = req_q[0];
                    check("req_address", 64'(address), 64'(h.addr));
                    check("req_index", 64'(register_index), 64'(h.idx));
                    check("req_write", 64'(mem_write), 64'(h.wr));
                    if (!mem_ready) begin
                        stall_cycles++;
                        check("stall_ctrl", 64'(incrementor_control), 64'd0);
                    end else begin
                        void'(req_q.pop_front());
                        if (req_q.size() == 0)
                            check("last_ctrl", 64'(incrementor_control), cur_desc ? 64'd0 : 64'd1);
                        else
                            check("step_ctrl", 64'(incrementor_control), cur_desc ? 64'd2 : 64'd1);
                    end
                end
            end
            if (done) begin
                if (done_q.size() == 0) flag("unexpected_done");
                else begin
                    e = done_q.pop_front();
                    check("done_address", 64'(address), 64'(e));
                    check("done_ctrl", 64'(incrementor_control), 64'd0);
                end
            end
            if (!busy) check("idle_ctrl", 64'(incrementor_control), 64'd0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_address"}, 64'(address), 64'd0);
        check({tag, "_ctrl"}, 64'(incrementor_control), 64'd0);
        check({tag, "_new_address"}, 64'(new_address), 64'd0);
        check({tag, "_mem_request"}, 64'(mem_request), 64'd0);
        check({tag, "_mem_write"}, 64'(mem_write), 64'd0);
        check({tag, "_index"}, 64'(register_index), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    task automatic run(input logic [31:0] base, input logic [7:0] list, input logic desc,
                       input logic wr, input int mode, input logic inject);
        int n;
        int cyc;
        @(posedge clock);
        #2;
        ready_mode      = mode;
        directed_stalls = 0;
        stall_cycles    = 0;
        cur_desc        = desc;
        base_address    = base;
        register_list   = list;
        descending      = desc;
        write           = wr;
        start           = 1'b1;
        expect_transfer(base, list, desc, wr, n);
        @(posedge clock);
        #1;
        start         = 1'b0;
        base_address  = $urandom;
        register_list = 8'($urandom);
        descending    = 1'($urandom);
        write         = 1'($urandom);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
            if (inject && cyc == 1) start = 1'b1;
            if (cyc == 2) start = 1'b0;
        end
        start = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done after %0d cycles, required one", cyc);
        end else begin
            check("latency", 64'(cyc), 64'(1 + n + stall_cycles));
        end
        @(posedge clock);
        #1;
        check("back_to_idle", 64'({busy, done}), 64'd0);
        check("requests_drained", 64'(req_q.size()), 64'd0);
        req_q.delete();
        load_q.delete();
        done_q.delete();
    endtask

    initial begin
        int n;
        #12;
        check_reset_outputs("reset");
        @(posedge clock);
        #3 reset = 1'b1;

        run(32'h0000_0100, 8'h15, 1'b0, 1'b0, 0, 1'b0);
        run(32'h0000_0200, 8'h0C, 1'b1, 1'b1, 0, 1'b0);
        run(32'h0000_0100, 8'h03, 1'b0, 1'b0, 2, 1'b0);
        run(32'h0000_0040, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        run(32'hFFFF_FFFF, 8'h03, 1'b0, 1'b0, 0, 1'b0);
        run(32'h0000_0300, 8'hA5, 1'b1, 1'b0, 0, 1'b1);

        // Asynchronous reset in the middle of a transfer
        @(posedge clock);
        #2;
        ready_mode    = 0;
        cur_desc      = 1'b0;
        base_address  = 32'h0000_0800;
        register_list = 8'hFF;
        descending    = 1'b0;
        write         = 1'b1;
        start         = 1'b1;
        expect_transfer(32'h0000_0800, 8'hFF, 1'b0, 1'b1, n);
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        check("pre_reset_request", 64'(mem_request), 64'd1);
        #3 reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        req_q.delete();
        load_q.delete();
        done_q.delete();
        @(posedge clock);
        #3 reset = 1'b1;

        run(32'h0000_0500, 8'h81, 1'b0, 1'b1, 0, 1'b0);
        run(32'h0000_0600, 8'h81, 1'b1, 1'b0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [7:0] l;
            l = 8'($urandom);
            run($urandom, l, 1'($urandom), 1'($urandom), 1, (l != 8'd0) && ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
